karatsuba_iter: RTL and testbench

KARATSUBA_ITER -- requirements
Module: karatsuba_iter

---
 rtl/kmul_pkg.sv | 17 +
 rtl/kmul_half_mult.sv | 17 +
 rtl/karatsuba_iter.sv | 186 ++++++++++++++++++
 tb/tb_karatsuba_iter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmul_pkg.sv
// kmul_pkg: shared types and constants for the iterative Karatsuba multiplier.
package kmul_pkg;

   // Default operand width of karatsuba_iter.
   localparam int KMUL_DEF_N = 32;

   // Sequencer states: one partial product per MUL_* state, then recombination.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MUL_LO  = 3'd1,
      MUL_HI  = 3'd2,
      MUL_MID = 3'd3,
      COMBINE = 3'd4,
      DONE    = 3'd5
   } kmul_state_t;

endpackage : kmul_pkg

// File: rtl/kmul_half_mult.sv
// kmul_half_mult: combinational W x W -> 2W unsigned multiplier.
// karatsuba_iter uses a single instance with W = H+1 so that the middle
// term's carried sums fit without truncation.
module kmul_half_mult #(
   parameter int W = 17
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);

   // Both operands are zero-extended to the product width before multiplying.
   always_comb begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
   end

endmodule : kmul_half_mult

// File: rtl/karatsuba_iter.sv
// karatsuba_iter: iterative Karatsuba multiplier, N x N -> 2N.
// Three partial products are formed on successive cycles by one shared
// (H+1)x(H+1) multiplier and recombined in a fourth cycle.
//
// Handshake: an operand pair moves on a rising edge where in_valid and
// in_ready are both 1; a result moves on a rising edge where out_valid and
// out_ready are both 1. in_ready is high only in IDLE, so the accept and
// result handshakes can never share a cycle.
//
// Optional feature macro: KARATSUBA_ITER_SIGNED_EN adds the sgn input and
// two's-complement operation (sign-magnitude around the unsigned core).
module karatsuba_iter
   import kmul_pkg::*;
#(
   parameter int N = KMUL_DEF_N,
   parameter int H = N / 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
`ifdef KARATSUBA_ITER_SIGNED_EN
   input  logic           sgn,
`endif
   input  logic [N-1:0]   X,
   input  logic [N-1:0]   Y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] Z
);

   // Reject unsupported geometries at elaboration.
   if ((N % 2) != 0 || N < 4) begin : g_bad_n
      $error("karatsuba_iter: N must be even and at least 4");
   end
   if (H != N / 2) begin : g_bad_h
      $error("karatsuba_iter: H is derived from N and must equal N/2");
   end

   localparam int PAD1 = 2 * N - (2 * H + 2);
   localparam int PAD0 = 2 * N - 2 * H;

   kmul_state_t state;

   logic [N-1:0]     xa;
   logic [N-1:0]     ya;
   logic [2*H-1:0]   p0;
   logic [2*H-1:0]   p2;
   logic [2*H+1:0]   p1;

   logic [N-1:0]     x_in;
   logic [N-1:0]     y_in;

   logic [H:0]       ma;
   logic [H:0]       mb;
   logic [2*H+1:0]   mp;

   logic [2*N-1:0]   mid;
   logic [2*N-1:0]   z_mag;
   logic [2*N-1:0]   z_next;

`ifdef KARATSUBA_ITER_SIGNED_EN
   logic             neg;
   logic             neg_in;

   // Signed operands are reduced to magnitudes; -2^(N-1) maps onto itself,
   // which is its correct unsigned magnitude.
   always_comb begin
      x_in   = (sgn && X[N-1]) ? -X : X;
      y_in   = (sgn && Y[N-1]) ? -Y : Y;
      neg_in = sgn && (X[N-1] ^ Y[N-1]);
   end
`else
   // Unsigned only: operands pass straight through.
   always_comb begin
      x_in = X;
      y_in = Y;
   end
`endif

   // Shared multiplier operand select; the middle sums keep their carry bit.
   always_comb begin
      ma = '0;
      mb = '0;
      case (state)
         MUL_LO: begin
            ma = {1'b0, xa[H-1:0]};
            mb = {1'b0, ya[H-1:0]};
         end
         MUL_HI: begin
            ma = {1'b0, xa[N-1:H]};
            mb = {1'b0, ya[N-1:H]};
         end
         MUL_MID: begin
            ma = {1'b0, xa[H-1:0]} + {1'b0, xa[N-1:H]};
            mb = {1'b0, ya[H-1:0]} + {1'b0, ya[N-1:H]};
         end
         default: begin
            ma = '0;
            mb = '0;
         end
      endcase
   end

   kmul_half_mult #(
      .W (H + 1)
   ) u_half_mult (
      .a (ma),
      .b (mb),
      .p (mp)
   );

   // Recombination: Z = p2*2^N + (p1 - p2 - p0)*2^H + p0, all in 2N bits.
   // The middle difference equals Xl*Yh + Xh*Yl and is never negative.
   always_comb begin
      mid   = {{PAD1{1'b0}}, p1} - {{PAD0{1'b0}}, p2} - {{PAD0{1'b0}}, p0};
      z_mag = ({{PAD0{1'b0}}, p2} << N) + (mid << H) + {{PAD0{1'b0}}, p0};
`ifdef KARATSUBA_ITER_SIGNED_EN
      z_next = neg ? -z_mag : z_mag;
`else
      z_next = z_mag;
`endif
   end

   // Sequencer with registered handshake outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Z         <= '0;
         p0        <= '0;
         p1        <= '0;
         p2        <= '0;
         xa        <= '0;
         ya        <= '0;
`ifdef KARATSUBA_ITER_SIGNED_EN
         neg       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xa       <= x_in;
                  ya       <= y_in;
`ifdef KARATSUBA_ITER_SIGNED_EN
                  neg      <= neg_in;
`endif
                  in_ready <= 1'b0;
                  state    <= MUL_LO;
               end
            end
            MUL_LO: begin
               p0    <= mp[2*H-1:0];
               state <= MUL_HI;
            end
            MUL_HI: begin
               p2    <= mp[2*H-1:0];
               state <= MUL_MID;
            end
            MUL_MID: begin
               p1    <= mp;
               state <= COMBINE;
            end
            COMBINE: begin
               Z         <= z_next;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule : karatsuba_iter

// File: tb/tb_karatsuba_iter.sv
// tb_karatsuba_iter: randomized self-checking bench for karatsuba_iter.
// Two instances: N=16 (signed cases when KARATSUBA_ITER_SIGNED_EN is set)
// and N=32. Expected products come from plain integer arithmetic.
module tb_karatsuba_iter;

   logic clk;
   logic rst;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, sgn16;
   logic [15:0] x16, y16;
   logic [31:0] z16;

   logic        in_valid32, in_ready32, out_valid32, out_ready32, sgn32;
   logic [31:0] x32, y32;
   logic [63:0] z32;

   int checks;
   int failures;

   karatsuba_iter #(.N(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
`ifdef KARATSUBA_ITER_SIGNED_EN
      .sgn       (sgn16),
`endif
      .X         (x16),
      .Y         (y16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .Z         (z16)
   );

   karatsuba_iter #(.N(32)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
`ifdef KARATSUBA_ITER_SIGNED_EN
      .sgn       (sgn32),
`endif
      .X         (x32),
      .Y         (y32),
      .out_valid (out_valid32),
      .out_ready (out_ready32),
      .Z         (z32)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: exact product, signed or unsigned, truncated to 2N bits.
   function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
      longint a, b;
      if (s) begin
         a = longint'($signed(x));
         b = longint'($signed(y));
      end else begin
         a = longint'({16'b0, x});
         b = longint'({16'b0, y});
      end
      return 32'(a * b);
   endfunction

   function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y);
      logic [63:0] a, b;
      a = {32'b0, x};
      b = {32'b0, y};
      return a * b;
   endfunction

   function automatic logic rand_sgn();
`ifdef KARATSUBA_ITER_SIGNED_EN
      return 1'($urandom_range(0, 1));
`else
      return 1'b0;
`endif
   endfunction

   // One transaction on the N=16 instance; called at a negedge, returns at a negedge.
   task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s,
                       input int delay, input string name);
      logic [31:0] exp;
      int          cnt;
      bit          bad;
      exp = model16(x, y, s);
      checks++;
      if (in_ready16 !== 1'b1) begin
         failures++;
         $display("FAIL %s_idle_ready got=%b exp=1", name, in_ready16);
      end
      in_valid16  = 1'b1;
      x16         = x;
      y16         = y;
      sgn16       = s;
      out_ready16 = (delay == 0);
      @(posedge clk);
      @(negedge clk);
      cnt = 0;
      bad = 0;
      while (out_valid16 !== 1'b1 && cnt < 12) begin
         if (in_ready16 !== 1'b0) bad = 1;
         in_valid16 = 1'($urandom_range(0, 1));
         x16        = 16'($urandom);
         y16        = 16'($urandom);
         sgn16      = rand_sgn();
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      in_valid16 = 1'b0;
      checks++;
      if (cnt != 4) begin
         failures++;
         $display("FAIL %s_latency got=%0d exp=4", name, cnt);
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL %s_busy_ready got=1 exp=0", name);
      end
      checks++;
      if (z16 !== exp) begin
         failures++;
         $display("FAIL %s_z got=%h exp=%h", name, z16, exp);
      end
      if (delay > 0) begin
         bad = 0;
         for (int i = 0; i < delay; i++) begin
            in_valid16 = 1'b1;
            x16        = 16'($urandom);
            y16        = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (out_valid16 !== 1'b1 || z16 !== exp || in_ready16 !== 1'b0) bad = 1;
         end
         in_valid16  = 1'b0;
         checks++;
         if (bad) begin
            failures++;
            $display("FAIL %s_backpressure got=%b/%h exp=1/%h", name, out_valid16, z16, exp);
         end
         out_ready16 = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
         failures++;
         $display("FAIL %s_release got=%b/%b exp=0/1", name, out_valid16, in_ready16);
      end
      checks++;
      if (z16 !== exp) begin
         failures++;
         $display("FAIL %s_z_hold got=%h exp=%h", name, z16, exp);
      end
   endtask

   // One transaction on the N=32 instance; called at a negedge, returns at a negedge.
   task automatic op32(input logic [31:0] x, input logic [31:0] y, input int delay,
                       input string name);
      logic [63:0] exp;
      int          cnt;
      bit          bad;
      exp = model32(x, y);
      checks++;
      if (in_ready32 !== 1'b1) begin
         failures++;
         $display("FAIL %s_idle_ready got=%b exp=1", name, in_ready32);
      end
      in_valid32  = 1'b1;
      x32         = x;
      y32         = y;
      out_ready32 = (delay == 0);
      @(posedge clk);
      @(negedge clk);
      cnt = 0;
      bad = 0;
      while (out_valid32 !== 1'b1 && cnt < 12) begin
         if (in_ready32 !== 1'b0) bad = 1;
         in_valid32 = 1'($urandom_range(0, 1));
         x32        = $urandom;
         y32        = $urandom;
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      in_valid32 = 1'b0;
      checks++;
      if (cnt != 4 || bad) begin
         failures++;
         $display("FAIL %s_latency got=%0d busy_ready_err=%0d exp=4/0", name, cnt, bad);
      end
      checks++;
      if (z32 !== exp) begin
         failures++;
         $display("FAIL %s_z got=%h exp=%h", name, z32, exp);
      end
      if (delay > 0) begin
         repeat (delay) begin
            @(posedge clk);
            @(negedge clk);
         end
         checks++;
         if (out_valid32 !== 1'b1 || z32 !== exp) begin
            failures++;
            $display("FAIL %s_stall got=%b/%h exp=1/%h", name, out_valid32, z32, exp);
         end
         out_ready32 = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || z32 !== exp) begin
         failures++;
         $display("FAIL %s_release got=%b/%b/%h exp=0/1/%h", name, out_valid32, in_ready32, z32, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || z16 !== 32'h0) begin
         failures++;
         $display("FAIL reset16 got=%b/%b/%h exp=1/0/0", in_ready16, out_valid16, z16);
      end
      checks++;
      if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || z32 !== 64'h0) begin
         failures++;
         $display("FAIL reset32 got=%b/%b/%h exp=1/0/0", in_ready32, out_valid32, z32);
      end
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      op16(16'hBFBF, 16'h2BFB, 1'b0, 0, "vec_bfbf");
      op16(16'hFFFF, 16'hFFFF, 1'b0, 0, "vec_ffff");
      op32(32'h0, 32'hDEADBEEF, 0, "vec32_zero");
      op32(32'hFFFFFFFF, 32'h00000002, 0, "vec32_ffx2");
   endtask

   task automatic test_backpressure();
      op16(16'h1234, 16'hFEDC, 1'b0, 10, "bp10");
   endtask

   task automatic test_back_to_back();
      op32(32'h8000_0001, 32'h7FFF_FFFF, 0, "b2b_a");
      op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "b2b_b");
      op32(32'h0001_0000, 32'h0000_FFFF, 0, "b2b_c");
   endtask

   task automatic test_reset_mid_op();
      bit bad;
      in_valid16 = 1'b1;
      x16        = 16'hA5A5;
      y16        = 16'h5A5B;
      sgn16      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid16 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || z16 !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid got=%b/%b/%h exp=1/0/0", in_ready16, out_valid16, z16);
      end
      bad = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid16 !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL rst_mid_no_pulse got=1 exp=0");
      end
   endtask

   task automatic test_signed();
`ifdef KARATSUBA_ITER_SIGNED_EN
      op16(16'hFFFF, 16'h0002, 1'b1, 0, "sgn_m1x2");
      op16(16'h8000, 16'h8000, 1'b1, 0, "sgn_min_sq");
      op16(16'hFFFF, 16'h0002, 1'b0, 0, "uns_ffx2");
      op16(16'h8000, 16'h7FFF, 1'b1, 2, "sgn_min_max");
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) begin
         op16(16'($urandom), 16'($urandom), rand_sgn(), $urandom_range(0, 3), "rand16");
      end
      for (int i = 0; i < 16; i++) begin
         op32($urandom, $urandom, $urandom_range(0, 3), "rand32");
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      in_valid16  = 1'b0;
      in_valid32  = 1'b0;
      out_ready16 = 1'b1;
      out_ready32 = 1'b1;
      sgn16       = 1'b0;
      sgn32       = 1'b0;
      x16         = '0;
      y16         = '0;
      x32         = '0;
      y32         = '0;
      test_reset();
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_signed();
      test_random();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_karatsuba_iter
